gd_update_ctrl: RTL

Iterative gradient-descent update controller for one Q8.8 parameter. It requests a gradient for the current x from an external gradient unit and scales it by the learning rate. It then applies the saturating update x ← sat(x − sat(lr·g)) and repeats until the step is small enough or an iteration cap is reached. It sits directly downstream of the gradient evaluator and produces the final parameter value for the host/readout logic.

---
 rtl/gd_update_ctrl_pkg.sv | 33 +++
 rtl/q8_8_sat_mul.sv | 22 ++
 rtl/gd_update_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/gd_update_ctrl_pkg.sv
// Shared Q8.8 constants, controller state encoding and saturation helpers
// for the gradient-descent update controller.
package gd_update_ctrl_pkg;

  localparam int FRACT_BITS = 8;
  localparam logic signed [15:0] Q8_8_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q8_8_MIN = 16'sh8000;
  localparam logic signed [32:0] WIDE_MAX = 33'sd32767;
  localparam logic signed [32:0] WIDE_MIN = -33'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_MUL    = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic is_clamped(input logic signed [32:0] v);
    return (v > WIDE_MAX) || (v < WIDE_MIN);
  endfunction

  function automatic logic [15:0] clamp16(input logic signed [32:0] v);
    if (v > WIDE_MAX) begin
      return Q8_8_MAX;
    end else if (v < WIDE_MIN) begin
      return Q8_8_MIN;
    end
    return v[15:0];
  endfunction

endpackage

// File: rtl/q8_8_sat_mul.sv
// Combinational Q8.8 x Q8.8 signed multiply with floor rescale and
// saturation to the Q8.8 range; o_sat flags a clamped result.
module q8_8_sat_mul
  import gd_update_ctrl_pkg::*;
(
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  output logic        [15:0] o_p,
  output logic               o_sat
);

  logic signed [31:0] w_prod;
  logic signed [31:0] w_shift;
  logic        [32:0] w_wide;

  assign w_prod  = i_a * i_b;
  assign w_shift = w_prod >>> FRACT_BITS;
  assign w_wide  = {w_shift[31], w_shift};
  assign o_p     = clamp16(w_wide);
  assign o_sat   = is_clamped(w_wide);

endmodule

// File: rtl/gd_update_ctrl.sv
// Iterative saturating gradient-descent controller for one Q8.8 parameter:
// request gradient, scale by learning rate, subtract, repeat until small step or cap.
module gd_update_ctrl
  import gd_update_ctrl_pkg::*;
#(
  parameter int          MAX_ITER = 255,
  parameter int          ITER_W   = 16,
  parameter logic [15:0] EPS      = 16'h0004
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       x_init,
  input  logic [15:0]       lr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [15:0]       req_x,
  input  logic              grad_valid,
  input  logic [15:0]       grad_in,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              sat_flag,
  output logic [15:0]       x_out,
  output logic [ITER_W-1:0] iter_count
);

  state_t              r_state;
  state_t              w_state_next;
  logic [15:0]         r_x;
  logic [15:0]         r_lr;
  logic [15:0]         r_g;
  logic [15:0]         r_step;
  logic [ITER_W-1:0]   r_iter;
  logic                r_conv;
  logic                r_sat;

  logic [15:0]         w_mul_p;
  logic                w_mul_sat;
  logic [16:0]         w_diff;
  logic [32:0]         w_diff_wide;
  logic [16:0]         w_step_abs;
  logic [ITER_W-1:0]   w_iter_inc;
  logic                w_small_step;
  logic                w_at_cap;

  q8_8_sat_mul u_mul (
    .i_a   (r_lr),
    .i_b   (r_g),
    .o_p   (w_mul_p),
    .o_sat (w_mul_sat)
  );

  // 17-bit magnitude so that 0x8000 reads as +32768 rather than wrapping.
  assign w_step_abs   = r_step[15] ? (17'd0 - {r_step[15], r_step}) : {1'b0, r_step};
  assign w_small_step = (w_step_abs <= {1'b0, EPS});
  assign w_diff       = {r_x[15], r_x} - {r_step[15], r_step};
  assign w_diff_wide  = {{16{w_diff[16]}}, w_diff};
  assign w_iter_inc   = r_iter + 1'b1;
  assign w_at_cap     = (w_iter_inc == ITER_W'(MAX_ITER));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_REQ;
      ST_REQ:    if (req_ready) w_state_next = ST_WAIT;
      ST_WAIT:   if (grad_valid) w_state_next = ST_MUL;
      ST_MUL:    w_state_next = ST_UPDATE;
      ST_UPDATE: w_state_next = (w_small_step || w_at_cap) ? ST_DONE : ST_REQ;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_lr   <= '0;
      r_g    <= '0;
      r_step <= '0;
      r_iter <= '0;
      r_conv <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x    <= x_init;
            r_lr   <= lr;
            r_iter <= '0;
            r_conv <= 1'b0;
            r_sat  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (grad_valid) r_g <= grad_in;
        end
        ST_MUL: begin
          r_step <= w_mul_p;
          if (w_mul_sat) r_sat <= 1'b1;
        end
        ST_UPDATE: begin
          r_x    <= clamp16(w_diff_wide);
          r_iter <= w_iter_inc;
          if (is_clamped(w_diff_wide)) r_sat <= 1'b1;
          if (w_small_step) r_conv <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_valid  = (r_state == ST_REQ);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign req_x      = r_x;
  assign x_out      = r_x;
  assign iter_count = r_iter;
  assign converged  = r_conv;
  assign sat_flag   = r_sat;

endmodule
